sprite_loader: RTL and testbench

//  Upstream feeder of sprite_storage. Consumes the byte stream from the SPI slave receiver and parses LOAD_SPRITE frames.

---
 rtl/kule_spi_pkg.sv | 19 +
 rtl/sprite_loader.sv | 124 ++++++++++++
 tb/tb_sprite_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/kule_spi_pkg.sv
// Shared definitions for the SPI-side sprite path: opcodes, loader FSM states
// and default sprite geometry (kept in step with sprite_storage's params.vh).
package kule_spi_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LOAD = 8'h01;

    localparam int DEF_SPRITE_NUM       = 4;
    localparam int DEF_SPRITE_SIZE      = 1024;
    localparam int DEF_SPRITE_ADDR_SIZE = 10;

    typedef enum logic [1:0] {
        IDLE,
        GET_IDX,
        DATA,
        DISCARD
    } loader_state_t;

endpackage

// File: rtl/sprite_loader.sv
// Parses LOAD_SPRITE frames from the SPI byte stream and turns each payload
// byte into one registered write strobe towards sprite_storage.
module sprite_loader
    import kule_spi_pkg::*;
#(
    parameter int SPRITE_NUM       = DEF_SPRITE_NUM,
    parameter int SPRITE_SIZE      = DEF_SPRITE_SIZE,
    parameter int SPRITE_ADDR_SIZE = DEF_SPRITE_ADDR_SIZE
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          frame_end,
    output logic [$clog2(SPRITE_NUM)-1:0] w_select,
    output logic                          w_en,
    output logic [SPRITE_ADDR_SIZE:0]     w_addr,
    output logic [7:0]                    w_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [SPRITE_NUM-1:0]         loaded
);

    localparam int SEL_W = $clog2(SPRITE_NUM);
    localparam logic [SPRITE_ADDR_SIZE-1:0] LAST_CNT = SPRITE_ADDR_SIZE'(SPRITE_SIZE / 2 - 1);

    loader_state_t                state, state_next;
    logic [SPRITE_ADDR_SIZE-1:0]  cnt, cnt_next;
    logic [SEL_W-1:0]             sel_next;
    logic [SPRITE_ADDR_SIZE:0]    addr_next;
    logic [7:0]                   data_next;
    logic                         w_en_next, done_next, err_next;
    logic [SPRITE_NUM-1:0]        loaded_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            w_select <= '0;
            w_en     <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            loaded   <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            w_select <= sel_next;
            w_en     <= w_en_next;
            w_addr   <= addr_next;
            w_data   <= data_next;
            done     <= done_next;
            err      <= err_next;
            loaded   <= loaded_next;
        end
    end

    // frame_end takes priority over a coincident byte in every state
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        sel_next    = w_select;
        addr_next   = w_addr;
        data_next   = w_data;
        w_en_next   = 1'b0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        loaded_next = loaded;
        case (state)
            IDLE: begin
                if (rx_valid && !frame_end) begin
                    if (rx_data == OP_LOAD) begin
                        state_next = GET_IDX;
                    end else if (rx_data != OP_NOP) begin
                        err_next   = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            GET_IDX: begin
                if (frame_end) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (rx_valid) begin
                    if (int'(rx_data) < SPRITE_NUM) begin
                        sel_next                      = rx_data[SEL_W-1:0];
                        loaded_next[rx_data[SEL_W-1:0]] = 1'b0;
                        cnt_next                      = '0;
                        state_next                    = DATA;
                    end else begin
                        err_next   = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            DATA: begin
                if (frame_end) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (rx_valid) begin
                    w_en_next = 1'b1;
                    data_next = rx_data;
                    addr_next = {cnt, 1'b0};
                    if (cnt == LAST_CNT) begin
                        done_next             = 1'b1;
                        loaded_next[w_select] = 1'b1;
                        state_next            = IDLE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: frame table plus hand sequences,
// with a scoreboard of expected write strobes checked as they appear.
module tb_sprite_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_end;
    logic [1:0] w_select;
    logic       w_en;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic       busy, done, err;
    logic [3:0] loaded;

    sprite_loader #(
        .SPRITE_NUM(4),
        .SPRITE_SIZE(8),
        .SPRITE_ADDR_SIZE(3)
    ) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_end(frame_end), .w_select(w_select), .w_en(w_en), .w_addr(w_addr),
        .w_data(w_data), .busy(busy), .done(done), .err(err), .loaded(loaded)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic        done;
        int unsigned cyc;
    } wr_t;

    typedef struct {
        logic [7:0] b [6];
        int         n;
        logic       fe;
        logic       busy_pre;
        int         exp_w;
        int         exp_done;
        int         exp_err;
        logic [3:0] exp_loaded;
    } frame_t;

    wr_t         sb[$];
    int          checks = 0, failures = 0;
    int          err_cnt = 0, done_cnt = 0, wen_cnt = 0;
    int unsigned cyc = 0;
    frame_t      tbl [7];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (done || err) check("done_err_exclusive", {31'b0, done & err}, 0);
            if (err) err_cnt++;
            if (done) done_cnt++;
            if (w_en) begin
                wen_cnt++;
                check("wen_expected", {31'b0, sb.size() > 0}, 1);
                if (sb.size() > 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check("w_select", {30'b0, w_select}, {30'b0, e.sel});
                    check("w_addr", {28'b0, w_addr}, {28'b0, e.addr});
                    check("w_data", {24'b0, w_data}, {24'b0, e.data});
                    check("done_on_strobe", {31'b0, done}, {31'b0, e.done});
                    check("write_latency", cyc, e.cyc);
                end
            end else if (done) begin
                check("done_without_wen", {31'b0, w_en}, 1);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 one cycle later.
    task automatic send_byte(input logic [7:0] d, input logic fe, input logic push,
                             input logic [1:0] sel, input int pidx);
        wr_t e;
        rx_valid  = 1'b1;
        rx_data   = d;
        frame_end = fe;
        @(posedge clock);
        #1;
        if (push) begin
            e.sel  = sel;
            e.addr = 4'(2 * pidx);
            e.data = d;
            e.done = (pidx == 3);
            e.cyc  = cyc;
            sb.push_back(e);
        end
        rx_valid  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        @(posedge clock);
        #1;
        frame_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic run_frame(input frame_t f, input string tag);
        int  e0, d0, w0;
        logic payload;
        e0 = err_cnt; d0 = done_cnt; w0 = wen_cnt;
        payload = (f.b[0] == 8'h01) && (f.b[1] < 8'd4);
        for (int i = 0; i < f.n; i++)
            send_byte(f.b[i], 1'b0, payload && i >= 2, f.b[1][1:0], i - 2);
        if (f.fe) begin
            check({tag, "_busy_pre_fe"}, {31'b0, busy}, {31'b0, f.busy_pre});
            pulse_frame_end();
        end
        idle(3);
        check({tag, "_writes"}, wen_cnt - w0, f.exp_w);
        check({tag, "_done"}, done_cnt - d0, f.exp_done);
        check({tag, "_err"}, err_cnt - e0, f.exp_err);
        check({tag, "_loaded"}, {28'b0, loaded}, {28'b0, f.exp_loaded});
        check({tag, "_busy_end"}, {31'b0, busy}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, d0, w0;
        frame_t full1;

        tbl[0] = '{'{8'h01, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4}, 6, 1'b0, 1'b0, 4, 1, 0, 4'b0100};
        tbl[1] = '{'{8'h01, 8'h05, 8'h11, 8'h22, 8'h00, 8'h00}, 4, 1'b1, 1'b1, 0, 0, 1, 4'b0100};
        tbl[2] = '{'{8'h01, 8'h00, 8'h10, 8'h32, 8'h54, 8'h76}, 6, 1'b0, 1'b0, 4, 1, 0, 4'b0101};
        tbl[3] = '{'{8'h7F, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00}, 3, 1'b1, 1'b1, 0, 0, 1, 4'b0101};
        tbl[4] = '{'{8'h01, 8'h01, 8'hAA, 8'hBB, 8'h00, 8'h00}, 4, 1'b1, 1'b1, 2, 0, 1, 4'b0101};
        tbl[5] = '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 1'b0, 0, 0, 0, 4'b0101};
        tbl[6] = '{'{8'h01, 8'h03, 8'h5A, 8'h6B, 8'h7C, 8'h8D}, 6, 1'b0, 1'b0, 4, 1, 0, 4'b1101};
        full1  = '{'{8'h01, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67}, 6, 1'b0, 1'b0, 4, 1, 0, 4'b1111};

        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; frame_end = 1'b0;
        idle(2);
        check("rst_w_en", {31'b0, w_en}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done_err", {30'b0, done, err}, 0);
        check("rst_outputs", {14'b0, w_select, w_addr, w_data, loaded}, 0);
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

        // truncation where frame_end coincides with the third payload byte
        e0 = err_cnt; d0 = done_cnt; w0 = wen_cnt;
        send_byte(8'h01, 1'b0, 1'b0, 2'd0, 0);
        send_byte(8'h01, 1'b0, 1'b0, 2'd0, 0);
        send_byte(8'hAA, 1'b0, 1'b1, 2'd1, 0);
        send_byte(8'hBB, 1'b0, 1'b1, 2'd1, 1);
        send_byte(8'hCC, 1'b1, 1'b0, 2'd1, 2);
        idle(3);
        check("fe_same_writes", wen_cnt - w0, 2);
        check("fe_same_err", err_cnt - e0, 1);
        check("fe_same_done", done_cnt - d0, 0);
        check("fe_same_loaded", {28'b0, loaded}, {28'b0, 4'b1101});

        // reload of an already loaded slot
        run_frame(full1, "load1");
        d0 = done_cnt;
        send_byte(8'h01, 1'b0, 1'b0, 2'd0, 0);
        send_byte(8'h01, 1'b0, 1'b0, 2'd0, 0);
        check("reload_idx_loaded", {28'b0, loaded}, {28'b0, 4'b1101});
        check("reload_busy", {31'b0, busy}, 1);
        send_byte(8'hEE, 1'b0, 1'b1, 2'd1, 0);
        check("reload_mid_loaded", {31'b0, loaded[1]}, 0);
        send_byte(8'hE1, 1'b0, 1'b1, 2'd1, 1);
        send_byte(8'hE2, 1'b0, 1'b1, 2'd1, 2);
        check("reload_pre_done_loaded", {31'b0, loaded[1]}, 0);
        send_byte(8'hE3, 1'b0, 1'b1, 2'd1, 3);
        idle(2);
        check("reload_done", done_cnt - d0, 1);
        check("reload_loaded", {28'b0, loaded}, {28'b0, 4'b1111});

        // asynchronous reset in the middle of DATA, while a strobe is high
        send_byte(8'h01, 1'b0, 1'b0, 2'd0, 0);
        send_byte(8'h03, 1'b0, 1'b0, 2'd0, 0);
        send_byte(8'h11, 1'b0, 1'b1, 2'd3, 0);
        send_byte(8'h22, 1'b0, 1'b1, 2'd3, 1);
        send_byte(8'h33, 1'b0, 1'b1, 2'd3, 2);
        check("pre_reset_wen", {31'b0, w_en}, 1);
        reset = 1'b1;
        #1;
        check("async_rst_w_en", {31'b0, w_en}, 0);
        check("async_rst_busy", {31'b0, busy}, 0);
        check("async_rst_outputs", {14'b0, w_select, w_addr, w_data, loaded}, 0);
        sb.delete();
        idle(2);
        reset = 1'b0;
        idle(1);
        tbl[6].exp_loaded = 4'b1000;
        run_frame(tbl[6], "post_reset");

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
